hoff_bit_unpack: RTL and testbench
==================================

// Module: hoff_bit_unpack
// PURPOSE
//  Receive-side counterpart of the Huffman bit packer. Takes MSB-first packed 32-bit words
//  and presents a left-aligned 32-bit bit window to the Huffman decoder.
//  The decoder consumes 0..32 bits per cycle. A 64-bit shift buffer absorbs word boundaries.
//  The final partial word is trimmed by a valid-bit count.
//  Sits between the DMA read FIFO and the Huffman code-table decoder.
// PARAMETERS
//  WORD_W   32  packed word width; fixed, only 32 is supported
//  BUF_W    64  bit buffer width; must equal 2*WORD_W
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   asynchronous, active-low reset (0 = reset)
//  flush        in   1   synchronous clear to IDLE; buffer and flags zeroed
//  word_in      in   32  packed bits; bit 31 is the oldest bit
//  word_valid   in   1   word_in is valid
//  word_last    in   1   this word ends the stream
//  last_bits    in   6   valid bits in the last word, 1..32; sampled only with word_last
//  word_ready   out  1   word is accepted when word_valid && word_ready
//  peek_bits    out  32  buf[63:32]; bits past avail_bits read as 0
//  peek_valid   out  1   avail_bits>=32, or (state==DRAIN && avail_bits>0)
//  avail_bits   out  7   valid bits in buffer, 0..64
//  consume_en   in   1   decoder takes consume_len bits this cycle
//  consume_len  in   6   0..32
//  stream_done  out  1   high in DONE
//  consume_err  out  1   sticky; set when consume_len>avail_bits or consume_len>32
// BEHAVIOUR
//  Reset (rst=0) and flush: buf=0, avail_bits=0, state=IDLE, word_ready=0, peek_valid=0,
//   stream_done=0, consume_err=0. Reset takes effect mid-stream immediately; any partial word is lost.
//  States:
//   IDLE:  word_ready=0; next cycle -> FILL (one-cycle start gap after reset or flush).
//   FILL:  word_ready=(avail_bits<=32). An accepted word_last moves the FSM to DRAIN.
//   DRAIN: word_ready=0; no more words. When avail_bits reaches 0 -> DONE.
//   DONE:  stream_done=1, word_ready=0. Stays until flush or reset.
//  word_ready depends only on registered state, so there is no combinational path from
//   word_valid or consume_en.
//  Per-cycle update, applied in this order:
//   1. Consume. If consume_en and consume_len<=avail_bits, then buf<<=consume_len and
//      avail-=consume_len.
//      Otherwise the buffer is unchanged and consume_err is set.
//   2. Load (on handshake). Let f be the avail_bits value after step 1 and n the number of bits
//      loaded (32, or last_bits when word_last). Place word_in at buf[63-f -: 32], with the
//      low 32-n bits of word_in masked to 0. Then avail=f+n.
//  Same-cycle consume + load is legal. Because word_ready requires avail<=32, f<=32 always
//   holds and a load can never overflow the 64-bit buffer.
//  Both updates complete in one cycle. peek_bits, avail_bits and peek_valid reflect the
//   update on the cycle after the edge (1-cycle latency from handshake to peek).
//  Bits beyond avail_bits are always 0 in buf.
//  last_bits==0 with word_last is treated as 32.
//  consume_len==0 with consume_en is a legal no-op.
//  After a load, avail_bits is 1..64. Arithmetic uses 7 bits; there is no wrap.
//  A word_valid pulse while word_ready=0 is ignored. Upstream must hold the word.
// TESTING
//  1. Reset, then words 0xF0000000 and 0x12345678 -> cycle after 2nd accept: avail=64,
//     peek=0xF0000000, word_ready=0.
//  2. Continue with consume_len=4 -> peek=0x00000001, avail=60. Then consume 28 -> peek=0x12345678,
//     avail=32, word_ready=1.
//  3. Same-cycle: avail=20, consume 5, accept 0xAAAAAAAA -> avail=47. peek = old bits<<5 followed
//     by 0xAAAAAAAA starting at buffer bit 48.
//  4. Last word 0xC0000000 with last_bits=3 on an empty buffer -> avail=3, peek=0xC0000000,
//     peek_valid=1 in DRAIN. Consume 3 -> avail=0 -> DONE, stream_done=1.
//  5. avail=10, consume_len=12 -> consume_err=1, buffer unchanged, avail=10. Then flush ->
//     consume_err=0, IDLE.
//  6. Assert rst=0 asynchronously mid-FILL with avail=40 -> all outputs at reset values
//     without a clock edge.

Source files
------------

// File: rtl/hoff_bit_unpack.sv
// Receive-side bit unpacker: accepts MSB-first packed words and presents a
// left-aligned 32-bit window over a 64-bit shift buffer to the Huffman decoder.
module hoff_bit_unpack #(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    input  logic              word_last,
    input  logic [5:0]        last_bits,
    output logic              word_ready,
    output logic [WORD_W-1:0] peek_bits,
    output logic              peek_valid,
    output logic [6:0]        avail_bits,
    input  logic              consume_en,
    input  logic [5:0]        consume_len,
    output logic              stream_done,
    output logic              consume_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [6:0] WORD_BITS = 7'(WORD_W);

    logic [1:0]        state_q, state_d;
    logic [BUF_W-1:0]  buf_q, buf_d;
    logic [6:0]        avail_q, avail_d;
    logic              err_q, err_d;

    logic              consume_ok;
    logic [BUF_W-1:0]  buf_c;
    logic [6:0]        avail_c;
    logic [6:0]        load_n;
    logic [WORD_W-1:0] keep_mask;
    logic [WORD_W-1:0] word_masked;
    logic [BUF_W-1:0]  load_vec;
    logic              accept;

    // Ready is decoded from registered state only, so no input reaches it combinationally.
    assign word_ready  = (state_q == ST_FILL) && (avail_q <= WORD_BITS);
    assign accept      = word_valid && word_ready;
    assign peek_bits   = buf_q[BUF_W-1 -: WORD_W];
    assign avail_bits  = avail_q;
    assign peek_valid  = (avail_q >= WORD_BITS) || ((state_q == ST_DRAIN) && (avail_q != 7'd0));
    assign stream_done = (state_q == ST_DONE);
    assign consume_err = err_q;

    // Bits loaded this cycle: a full word, or the trimmed count of the final word.
    always_comb begin
        load_n = WORD_BITS;
        if (word_last && (last_bits != 6'd0) && (last_bits <= 6'd32)) begin
            load_n = {1'b0, last_bits};
        end
    end

    // Keep bit gi of the incoming word when it lies within the top load_n bits.
    generate
        for (genvar gi = 0; gi < WORD_W; gi++) begin : g_mask
            localparam logic [6:0] BIT_POS = 7'(gi);
            assign keep_mask[gi] = (BIT_POS + load_n) >= WORD_BITS;
        end
    endgenerate

    assign word_masked = word_in & keep_mask;

    always_comb begin
        consume_ok = consume_en
                     && ({1'b0, consume_len} <= avail_q)
                     && (consume_len <= 6'd32);
        buf_c      = consume_ok ? (buf_q << consume_len) : buf_q;
        avail_c    = consume_ok ? (avail_q - {1'b0, consume_len}) : avail_q;
        // avail_c never exceeds 32 when a load happens, so the word always fits.
        load_vec   = {word_masked, {(BUF_W-WORD_W){1'b0}}} >> avail_c;
    end

    always_comb begin
        buf_d   = buf_c;
        avail_d = avail_c;
        err_d   = err_q | (consume_en && !consume_ok);
        state_d = state_q;

        if (accept) begin
            buf_d   = buf_c | load_vec;
            avail_d = avail_c + load_n;
        end

        case (state_q)
            ST_IDLE:  state_d = ST_FILL;
            ST_FILL:  if (accept && word_last) state_d = ST_DRAIN;
            ST_DRAIN: if (avail_d == 7'd0) state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase

        if (flush) begin
            buf_d   = '0;
            avail_d = 7'd0;
            err_d   = 1'b0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            buf_q   <= '0;
            avail_q <= 7'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            avail_q <= avail_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_hoff_bit_unpack.sv
// Bench for hoff_bit_unpack: a bit-queue model checked every cycle, plus directed
// scenarios with hand-computed literal expectations and a randomized phase.
module tb_hoff_bit_unpack;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] word_in = '0;
    logic        word_valid = 1'b0;
    logic        word_last = 1'b0;
    logic [5:0]  last_bits = '0;
    logic        word_ready;
    logic [31:0] peek_bits;
    logic        peek_valid;
    logic [6:0]  avail_bits;
    logic        consume_en = 1'b0;
    logic [5:0]  consume_len = '0;
    logic        stream_done;
    logic        consume_err;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    hoff_bit_unpack dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .word_in    (word_in),
        .word_valid (word_valid),
        .word_last  (word_last),
        .last_bits  (last_bits),
        .word_ready (word_ready),
        .peek_bits  (peek_bits),
        .peek_valid (peek_valid),
        .avail_bits (avail_bits),
        .consume_en (consume_en),
        .consume_len(consume_len),
        .stream_done(stream_done),
        .consume_err(consume_err)
    );

    // Reference model: the buffer is just an ordered queue of pending bits.
    bit mq[$];
    bit m_started, m_ended, m_err;

    function automatic void model_reset();
        mq.delete();
        m_started = 1'b0;
        m_ended   = 1'b0;
        m_err     = 1'b0;
    endfunction

    function automatic bit m_ready();
        return m_started && !m_ended && (mq.size() <= 32);
    endfunction

    function automatic logic [31:0] m_peek();
        logic [31:0] r = '0;
        for (int i = 0; i < 32 && i < mq.size(); i++) r[31-i] = mq[i];
        return r;
    endfunction

    function automatic bit m_peek_valid();
        return (mq.size() >= 32) || (m_ended && mq.size() > 0);
    endfunction

    function automatic bit m_done();
        return m_ended && (mq.size() == 0);
    endfunction

    function automatic void model_step();
        bit rdy;
        int n;
        if (flush) begin
            model_reset();
            return;
        end
        rdy = m_ready();
        if (consume_en) begin
            if (int'(consume_len) <= mq.size() && consume_len <= 6'd32) begin
                for (int i = 0; i < int'(consume_len); i++) void'(mq.pop_front());
            end else begin
                m_err = 1'b1;
            end
        end
        if (word_valid && rdy) begin
            n = (word_last && last_bits != 6'd0) ? int'(last_bits) : 32;
            for (int i = 0; i < n; i++) mq.push_back(word_in[31-i]);
            if (word_last) m_ended = 1'b1;
        end
        m_started = 1'b1;
    endfunction

    always @(posedge clk) if (rst) model_step();
    always @(negedge rst) model_reset();

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Single per-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("cyc_word_ready",  64'(word_ready),  64'(m_ready()));
            chk("cyc_peek_bits",   64'(peek_bits),   64'(m_peek()));
            chk("cyc_peek_valid",  64'(peek_valid),  64'(m_peek_valid()));
            chk("cyc_avail_bits",  64'(avail_bits),  64'(mq.size()));
            chk("cyc_stream_done", 64'(stream_done), 64'(m_done()));
            chk("cyc_consume_err", 64'(consume_err), 64'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w, input logic l, input logic [5:0] lb);
        word_in    = w;
        word_last  = l;
        last_bits  = lb;
        word_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (word_ready) begin
                tick();
                word_valid = 1'b0;
                word_last  = 1'b0;
                return;
            end
            tick();
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        checks++;
        errors++;
        $display("FAIL push_timeout got=no_ready expected=ready_within_20 (t=%0t)", $time);
    endtask

    task automatic consume(input logic [5:0] len);
        consume_en  = 1'b1;
        consume_len = len;
        tick();
        consume_en  = 1'b0;
        consume_len = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lim;
        model_reset();
        tick();
        tick();
        rst = 1'b1;
        check_en = 1'b1;

        // Two full words, then window shows the first.
        push(32'hF000_0000, 1'b0, 6'd0);
        push(32'h1234_5678, 1'b0, 6'd0);
        chk("s1_avail", 64'(avail_bits), 64'd64);
        chk("s1_peek",  64'(peek_bits),  64'hF000_0000);
        chk("s1_ready", 64'(word_ready), 64'd0);
        chk("s1_model_peek",  64'(m_peek()),   64'hF000_0000);
        chk("s1_model_avail", 64'(mq.size()),  64'd64);

        consume(6'd4);
        chk("s2_peek4",  64'(peek_bits),  64'h0000_0001);
        chk("s2_avail4", 64'(avail_bits), 64'd60);
        consume(6'd28);
        chk("s2_peek32",  64'(peek_bits),  64'h1234_5678);
        chk("s2_avail32", 64'(avail_bits), 64'd32);
        chk("s2_ready",   64'(word_ready), 64'd1);

        // Same-cycle consume and load.
        consume(6'd12);
        chk("s3_pre_avail", 64'(avail_bits), 64'd20);
        chk("s3_pre_peek",  64'(peek_bits),  64'h4567_8000);
        consume_en  = 1'b1;
        consume_len = 6'd5;
        word_in     = 32'hAAAA_AAAA;
        word_valid  = 1'b1;
        tick();
        consume_en  = 1'b0;
        word_valid  = 1'b0;
        chk("s3_avail", 64'(avail_bits), 64'd47);
        chk("s3_peek",  64'(peek_bits),  64'hACF1_5555);

        // Trimmed last word on an empty buffer, then drain to DONE.
        do_flush();
        push(32'hC000_0000, 1'b1, 6'd3);
        chk("s4_avail", 64'(avail_bits), 64'd3);
        chk("s4_peek",  64'(peek_bits),  64'hC000_0000);
        chk("s4_pvalid", 64'(peek_valid), 64'd1);
        chk("s4_notdone", 64'(stream_done), 64'd0);
        consume(6'd3);
        chk("s4_avail0", 64'(avail_bits), 64'd0);
        chk("s4_done",   64'(stream_done), 64'd1);

        // Over-consume error and flush clear.
        do_flush();
        push(32'h1234_5678, 1'b0, 6'd0);
        consume(6'd22);
        chk("s5_avail10", 64'(avail_bits), 64'd10);
        chk("s5_peek10",  64'(peek_bits),  64'h9E00_0000);
        consume(6'd12);
        chk("s5_err",       64'(consume_err), 64'd1);
        chk("s5_avail_kept", 64'(avail_bits), 64'd10);
        chk("s5_peek_kept",  64'(peek_bits),  64'h9E00_0000);
        do_flush();
        chk("s5_err_clr",  64'(consume_err), 64'd0);
        chk("s5_idle_rdy", 64'(word_ready),  64'd0);

        // Asynchronous reset mid-FILL.
        push(32'hDEAD_BEEF, 1'b0, 6'd0);
        push(32'hCAFE_F00D, 1'b0, 6'd0);
        consume(6'd24);
        chk("s6_avail40", 64'(avail_bits), 64'd40);
        #2;
        rst = 1'b0;
        #1;
        chk("s6_rst_avail", 64'(avail_bits), 64'd0);
        chk("s6_rst_peek",  64'(peek_bits),  64'd0);
        chk("s6_rst_pval",  64'(peek_valid), 64'd0);
        chk("s6_rst_rdy",   64'(word_ready), 64'd0);
        chk("s6_rst_done",  64'(stream_done), 64'd0);
        tick();
        rst = 1'b1;

        // Randomized traffic checked against the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            flush = (m_done() || $urandom_range(0, 299) == 0);
            word_valid = ($urandom_range(0, 3) != 0);
            word_in    = $urandom;
            word_last  = ($urandom_range(0, 11) == 0);
            last_bits  = 6'($urandom_range(0, 32));
            consume_en = ($urandom_range(0, 2) != 0);
            lim = (mq.size() < 32) ? mq.size() : 32;
            if ($urandom_range(0, 19) == 0) consume_len = 6'($urandom_range(0, 40));
            else consume_len = 6'($urandom_range(0, lim));
            tick();
        end
        flush = 1'b0;
        word_valid = 1'b0;
        consume_en = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
